// File: rtl/checker_pkg.sv
// Shared types and helpers for the sequential clause checker: FSM state encoding,
// parameter defaults, accumulator sizing and flattened-bus field offsets.
package checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StCompare,
    StDone
  } state_e;

  localparam int unsigned DefNumVars    = 2;
  localparam int unsigned DefNumClauses = 2;
  localparam int unsigned DefWidth      = 8;

  // Wide enough for NUM_VARS full-scale products plus the constant, with a sign bit.
  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned num_vars);
    return 2 * width + $clog2(num_vars + 1) + 1;
  endfunction

  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/clause_mac.sv
// One clause lane: signed multiply-accumulate of coef*var terms, then the constant,
// with a combinational "next accumulator <= 0" result for the top to register.
module clause_mac #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 19
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             add_prod_i,
  input  logic             add_const_i,
  input  logic [WIDTH-1:0] coef_i,
  input  logic [WIDTH-1:0] var_i,
  input  logic [WIDTH-1:0] const_i,
  output logic             sat_o
);

  localparam int unsigned ProdW = 2 * WIDTH;

  logic signed [ProdW-1:0]     prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, const_ext;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  assign prod      = $signed(coef_i) * $signed(var_i);
  assign prod_ext  = {{(ACC_WIDTH - ProdW){prod[ProdW-1]}}, prod};
  assign const_ext = {{(ACC_WIDTH - WIDTH){const_i[WIDTH-1]}}, const_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_prod_i) begin
      acc_d = acc_q + prod_ext;
    end else if (add_const_i) begin
      acc_d = acc_q + const_ext;
    end
  end

  assign sat_o = acc_d[ACC_WIDTH-1] | (acc_d == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/clause_checker_seq.sv
// Sequential linear-clause checker: snapshots one assignment, accumulates one variable
// per cycle in every clause lane, then registers per-clause flags. Optional
// CHECKER_COUNT_EN adds a registered unsatisfied-clause count output.
module clause_checker_seq
  import checker_pkg::*;
#(
  parameter int unsigned NUM_VARS    = DefNumVars,
  parameter int unsigned NUM_CLAUSES = DefNumClauses,
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned ACC_WIDTH   = acc_width(WIDTH, NUM_VARS)
) (
  input  logic                                      in_clk,
  input  logic                                      in_reset_n,
  input  logic                                      in_enable,
  input  logic                                      in_start,
  input  logic [NUM_CLAUSES*(NUM_VARS+1)*WIDTH-1:0] in_coefficients,
  input  logic [NUM_VARS*WIDTH-1:0]                 in_current_assignment,
  output logic                                      out_busy,
  output logic                                      out_done,
  output logic [NUM_CLAUSES-1:0]                    out_satisfied_flag,
  output logic                                      out_all_satisfied
`ifdef CHECKER_COUNT_EN
  ,
  output logic [$clog2(NUM_CLAUSES+1)-1:0]          out_unsat_count
`endif
);

  localparam int unsigned IdxW  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int unsigned CoefW = NUM_CLAUSES * (NUM_VARS + 1) * WIDTH;
  localparam int unsigned VarW  = NUM_VARS * WIDTH;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CoefW-1:0]       coef_q;
  logic [VarW-1:0]        y_q;
  logic                   snap, clear, add_prod, add_const;
  logic [NUM_CLAUSES-1:0] lane_sat, flags_q;
  logic                   busy_q, done_q, all_q;
  logic [WIDTH-1:0]       y_cur;

  assign y_cur = y_q[field_lsb(32'(idx_q), WIDTH) +: WIDTH];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap      = 1'b0;
    clear     = 1'b0;
    add_prod  = 1'b0;
    add_const = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          snap    = 1'b1;
          clear   = 1'b1;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        add_prod = 1'b1;
        if (idx_q == IdxW'(NUM_VARS - 1)) begin
          state_d = StCompare;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StCompare: begin
        add_const = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      coef_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= '0;
      all_q   <= 1'b0;
    end else if (in_enable) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == StAccum) || (state_d == StCompare);
      done_q  <= (state_d == StDone);
      if (snap) begin
        coef_q <= in_coefficients;
        y_q    <= in_current_assignment;
      end
      if (state_q == StCompare) begin
        flags_q <= lane_sat;
        all_q   <= &lane_sat;
      end
    end
  end

  for (genvar c = 0; c < NUM_CLAUSES; c++) begin : g_lane
    localparam int unsigned Base = c * (NUM_VARS + 1);
    logic [WIDTH-1:0] lane_coef, lane_a0;

    assign lane_coef = coef_q[field_lsb(Base + 32'(idx_q), WIDTH) +: WIDTH];
    assign lane_a0   = coef_q[field_lsb(Base + NUM_VARS, WIDTH) +: WIDTH];

    clause_mac #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
      .clk_i      (in_clk),
      .rst_ni     (in_reset_n),
      .en_i       (in_enable),
      .clear_i    (clear),
      .add_prod_i (add_prod),
      .add_const_i(add_const),
      .coef_i     (lane_coef),
      .var_i      (y_cur),
      .const_i    (lane_a0),
      .sat_o      (lane_sat[c])
    );
  end

`ifdef CHECKER_COUNT_EN
  localparam int unsigned CntW = $clog2(NUM_CLAUSES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = CntW'(NUM_CLAUSES);
    for (int unsigned c = 0; c < NUM_CLAUSES; c++) begin
      cnt_d = cnt_d - CntW'(lane_sat[c]);
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      cnt_q <= '0;
    end else if (in_enable && (state_q == StCompare)) begin
      cnt_q <= cnt_d;
    end
  end

  assign out_unsat_count = cnt_q;
`endif

  assign out_busy           = busy_q;
  assign out_done           = done_q;
  assign out_satisfied_flag = flags_q;
  assign out_all_satisfied  = all_q;

endmodule

// File: tb/tb_clause_checker_seq.sv
// Scoreboard bench for clause_checker_seq: default instance plus a 5-variable,
// 4-clause instance; expected results are queued at start and checked on done.
module tb_clause_checker_seq;

  localparam int unsigned NV  = 2;
  localparam int unsigned NC  = 2;
  localparam int unsigned W   = 8;
  localparam int unsigned NV5 = 5;
  localparam int unsigned NC5 = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b1;
  logic start  = 1'b0;
  logic start5 = 1'b0;

  logic [NC*(NV+1)*W-1:0]   coef;
  logic [NV*W-1:0]          y;
  logic [NC5*(NV5+1)*W-1:0] coef5;
  logic [NV5*W-1:0]         y5;
  logic                     busy, done, all_sat, busy5, done5, all5;
  logic [NC-1:0]            flags;
  logic [NC5-1:0]           flags5;
`ifdef CHECKER_COUNT_EN
  logic [1:0]               cnt;
  logic [2:0]               cnt5;
`endif

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0]  flags;
    logic        all;
    int unsigned cnt;
    int unsigned done_cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q5[$];
  exp_t m2, m5;
  logic done_prev  = 1'b0;
  logic done5_prev = 1'b0;

  clause_checker_seq #(
    .NUM_VARS   (NV),
    .NUM_CLAUSES(NC),
    .WIDTH      (W)
  ) dut (
    .in_clk               (clk),
    .in_reset_n           (rst_n),
    .in_enable            (en),
    .in_start             (start),
    .in_coefficients      (coef),
    .in_current_assignment(y),
    .out_busy             (busy),
    .out_done             (done),
    .out_satisfied_flag   (flags),
    .out_all_satisfied    (all_sat)
`ifdef CHECKER_COUNT_EN
    ,
    .out_unsat_count      (cnt)
`endif
  );

  clause_checker_seq #(
    .NUM_VARS   (NV5),
    .NUM_CLAUSES(NC5),
    .WIDTH      (W)
  ) dut5 (
    .in_clk               (clk),
    .in_reset_n           (rst_n),
    .in_enable            (en),
    .in_start             (start5),
    .in_coefficients      (coef5),
    .in_current_assignment(y5),
    .out_busy             (busy5),
    .out_done             (done5),
    .out_satisfied_flag   (flags5),
    .out_all_satisfied    (all5)
`ifdef CHECKER_COUNT_EN
    ,
    .out_unsat_count      (cnt5)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per rising edge of done.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        m2 = q2.pop_front();
        chk("flags", 32'(flags), 32'(m2.flags[NC-1:0]));
        chk("all_satisfied", 32'(all_sat), 32'(m2.all));
        chk("done_cycle", cyc, m2.done_cyc);
`ifdef CHECKER_COUNT_EN
        chk("unsat_count", 32'(cnt), m2.cnt);
`endif
      end
    end
    done_prev = done;
  end

  always @(negedge clk) begin
    if (done5 && !done5_prev) begin
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done5: got done at cycle %0d, expected none", cyc);
      end else begin
        m5 = q5.pop_front();
        chk("flags5", 32'(flags5), 32'(m5.flags));
        chk("all_satisfied5", 32'(all5), 32'(m5.all));
        chk("done_cycle5", cyc, m5.done_cyc);
`ifdef CHECKER_COUNT_EN
        chk("unsat_count5", 32'(cnt5), m5.cnt);
`endif
      end
    end
    done5_prev = done5;
  end

  function automatic logic [47:0] pack2(input int c0y0, input int c0y1, input int c0a0,
                                        input int c1y0, input int c1y1, input int c1a0);
    return {8'(c1a0), 8'(c1y1), 8'(c1y0), 8'(c0a0), 8'(c0y1), 8'(c0y0)};
  endfunction

  function automatic logic [15:0] vars2(input int y0, input int y1);
    return {8'(y1), 8'(y0)};
  endfunction

  function automatic exp_t mk2(input logic [1:0] f, input int unsigned n, input int unsigned dc);
    exp_t e;
    e.flags    = {2'b00, f};
    e.all      = &f;
    e.cnt      = n;
    e.done_cyc = dc;
    return e;
  endfunction

  // Issue one start on the default instance; returns at the negedge after accept.
  task automatic run2(input logic [47:0] c, input logic [15:0] yv, input logic [1:0] f,
                      input int unsigned n, input int unsigned extra);
    @(negedge clk);
    coef  = c;
    y     = yv;
    start = 1'b1;
    q2.push_back(mk2(f, n, cyc + NV + 2 + extra));
    @(negedge clk);
    start = 1'b0;
    coef  = ~c;
    y     = ~yv;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_q2();
    int n = 0;
    while (q2.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", q2.size(), 0);
    @(negedge clk);
  endtask

  logic [47:0] c1;
  int unsigned c0;

  initial begin
    coef  = '0;
    y     = '0;
    coef5 = '0;
    y5    = '0;
    c1    = pack2(1, 1, -5, 2, -1, 0);

    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_all", 32'(all_sat), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed vectors on clause0 = y0+y1-5, clause1 = 2*y0-y1.
    run2(c1, vars2(2, 3), 2'b01, 1, 0);  wait_q2();
    run2(c1, vars2(0, 0), 2'b11, 0, 0);  wait_q2();
    run2(c1, vars2(5, -1), 2'b01, 1, 0); wait_q2();
    run2(c1, vars2(-3, 4), 2'b11, 0, 0); wait_q2();
    run2(c1, vars2(3, 3), 2'b00, 2, 0);  wait_q2();
    // Full-scale negative: 2*16384-128 stays positive, no wrap.
    run2({6{8'h80}}, {2{8'h80}}, 2'b00, 2, 0); wait_q2();

    // Five-variable instance: only constants nonzero, a0 = (-1, 0, 1, 0).
    @(negedge clk);
    coef5 = '0;
    coef5[(0*6+5)*8 +: 8] = 8'hFF;
    coef5[(2*6+5)*8 +: 8] = 8'h01;
    y5     = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
    start5 = 1'b1;
    begin
      exp_t e;
      e.flags    = 4'b1011;
      e.all      = 1'b0;
      e.cnt      = 1;
      e.done_cyc = cyc + NV5 + 2;
      q5.push_back(e);
    end
    @(negedge clk);
    start5 = 1'b0;
    coef5  = '1;
    chk("busy5_after_accept", 32'(busy5), 32'd1);
    for (int i = 0; i < 20 && q5.size() > 0; i++) @(negedge clk);
    chk("done5_timeout", q5.size(), 0);

    // Start held through busy and DONE (5 edges): exactly one run.
    @(negedge clk);
    coef  = c1;
    y     = vars2(2, 3);
    start = 1'b1;
    c0    = cyc;
    q2.push_back(mk2(2'b01, 1, c0 + 4));
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_q2();
    repeat (6) @(negedge clk);

    // Held for 6 edges: second run accepted in the IDLE after DONE.
    @(negedge clk);
    coef  = c1;
    y     = vars2(3, 3);
    start = 1'b1;
    c0    = cyc;
    q2.push_back(mk2(2'b00, 2, c0 + 4));
    q2.push_back(mk2(2'b00, 2, c0 + 9));
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_q2();
    repeat (6) @(negedge clk);

    // Enable low for 3 cycles in ACCUM delays done by exactly 3.
    run2(c1, vars2(2, 3), 2'b01, 1, 3);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_frozen", 32'(busy), 32'd1);
    en = 1'b1;
    wait_q2();

    // Reset mid-ACCUM aborts with no done.
    @(negedge clk);
    coef  = c1;
    y     = vars2(3, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_all", 32'(all_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    run2(c1, vars2(2, 3), 2'b01, 1, 0);
    wait_q2();

    repeat (4) @(negedge clk);
    chk("q2_drained", q2.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
